// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-memory bus bundle.
// slave = LSU side (req in, resp/mem out); master = core + memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_signed,
    input  req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_a, mem_wd, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_signed,
    output req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a word memory.
// Ports: clk, rst (async active-low), bus (load_store_unit_if.slave).
// Option: LSU_MISALIGN_CHECK_EN flags misaligned half/word with resp_err.
module load_store_unit #(
  parameter int AW = 10
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        mem_we_q, mem_we_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        mis;
  logic        unused_addr;

  assign unused_addr = ^bus.req_addr[31:AW+2];

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      (bus.req_size == 2'b01): mis = bus.req_addr[0];
      bus.req_size[1]:         mis = |bus.req_addr[1:0];
      default:                 mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic        sgn
  );
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? w[31:16] : w[15:0];
    r  = w;
    unique case (1'b1)
      (size == 2'b00):
        r = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      (size == 2'b01):
        r = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Read-modify-write: only the addressed lane takes the new data.
  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [31:0] wd,
    input logic [1:0]  size,
    input logic [1:0]  off
  );
    logic [31:0] mask;
    logic [31:0] data;
    mask = 32'hFFFF_FFFF;
    data = wd;
    unique case (1'b1)
      (size == 2'b00): begin
        mask = 32'h0000_00FF << {off, 3'b000};
        data = {24'h0, wd[7:0]} << {off, 3'b000};
      end
      (size == 2'b01): begin
        mask = 32'h0000_FFFF << {off[1], 4'b0000};
        data = {16'h0, wd[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wd;
      end
    endcase
    return (w & ~mask) | (data & mask);
  endfunction

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    mem_wd_d     = mem_wd_q;
    mem_we_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          off_d   = bus.req_addr[1:0];
          wdata_d = bus.req_wdata;
          idx_d   = bus.req_addr[AW+1:2];
          if (mis) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
            resp_err_d   = 1'b1;
          end else if (bus.req_we && bus.req_size[1]) begin
            state_d  = WR;
            mem_we_d = 1'b1;
            mem_wd_d = bus.req_wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (we_q) begin
          state_d  = WR;
          mem_we_d = 1'b1;
          mem_wd_d = merge(bus.mem_rd, wdata_q, size_q, off_q);
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext(bus.mem_rd, size_q, off_q, sgn_q);
          resp_err_d   = 1'b0;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
      idx_q        <= '0;
      mem_wd_q     <= 32'h0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      mem_wd_q     <= mem_wd_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_a      = {{(32-AW){1'b0}}, idx_q};
  assign bus.mem_wd     = mem_wd_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a registered-read word memory.
// Expected responses are queued at accept and checked on resp_valid.
module tb_load_store_unit;

  logic clk;
  logic rst;

  load_store_unit_if bus ();

  load_store_unit #(.AW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_a;
  logic [31:0] pl_d;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_a[9:0]] <= bus.mem_wd;
    else if (pl_en) mem[pl_a] <= pl_d;
    bus.mem_rd <= mem[bus.mem_a[9:0]];
  end

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  int   we_a = 0;
  int   last_resp = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.mem_we) begin
      we_cnt++;
      we_a = int'(bus.mem_a);
    end
    if (bus.resp_valid) begin
      last_resp = cyc;
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.tag, "_rdata"}, bus.resp_rdata, e.rdata);
        chk({e.tag, "_err"}, {31'h0, bus.resp_err}, {31'h0, e.err});
        chk({e.tag, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input string tag, input logic we,
                      input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee,
                      input int lat, input bit push, input bit hold,
                      output int acc);
    exp_t e;
    acc = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    for (int i = 0; i < 40 && !bus.req_ready; i++) @(negedge clk);
    if (!bus.req_ready) begin
      chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (push) begin
      e.tag = tag;
      e.rdata = er;
      e.err = ee;
      e.lat = lat;
      e.acc = acc;
      sbq.push_back(e);
    end
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("resp_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  int acc;
  int acc2;
  int w0;

  initial begin
    rst            = 1'b0;
    pl_en          = 1'b0;
    pl_a           = '0;
    pl_d           = '0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", {31'h0, bus.mem_we}, 32'd0);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wd", bus.mem_wd, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, bus.req_ready}, 32'd1);

    w0 = we_cnt;
    send("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF,
         32'h0, 1'b0, 2, 1'b1, 1'b0, acc);
    wait_done();
    chk("st_word_pulses", 32'(we_cnt - w0), 32'd1);
    chk("st_word_mem_a", 32'(we_a), 32'd4);
    chk("st_word_mem", mem[4], 32'hDEADBEEF);
    send("ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
         32'hDEADBEEF, 1'b0, 3, 1'b1, 1'b0, acc);
    wait_done();

    preload(10'd4, 32'h11223344);
    w0 = we_cnt;
    send("st_byte", 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFA5,
         32'h0, 1'b0, 4, 1'b1, 1'b0, acc);
    wait_done();
    chk("st_byte_pulses", 32'(we_cnt - w0), 32'd1);
    chk("st_byte_mem", mem[4], 32'h1122A544);

    preload(10'd4, 32'h80000000);
    send("ld_sb", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,
         32'hFFFFFF80, 1'b0, 3, 1'b1, 1'b0, acc);
    wait_done();
    send("ld_ub", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,
         32'h00000080, 1'b0, 3, 1'b1, 1'b0, acc);
    wait_done();
    send("ld_sh", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,
         32'hFFFF8000, 1'b0, 3, 1'b1, 1'b0, acc);
    wait_done();
    send("ld_uh", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,
         32'h00008000, 1'b0, 3, 1'b1, 1'b0, acc);
    wait_done();
    send("st_half", 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234,
         32'h0, 1'b0, 4, 1'b1, 1'b0, acc);
    wait_done();
    chk("st_half_mem", mem[4], 32'h12340000);

    preload(10'd0, 32'hCAFEF00D);
    w0 = we_cnt;
`ifdef LSU_MISALIGN_CHECK_EN
    send("ld_mis", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0,
         32'h0, 1'b1, 1, 1'b1, 1'b0, acc);
`else
    send("ld_mis", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0,
         32'hCAFEF00D, 1'b0, 3, 1'b1, 1'b0, acc);
`endif
    wait_done();
    chk("ld_mis_no_write", 32'(we_cnt - w0), 32'd0);

    send("ld_wrap", 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0,
         32'h12340000, 1'b0, 3, 1'b1, 1'b0, acc);
    wait_done();
    chk("ld_wrap_mem_a", bus.mem_a, 32'd4);

    preload(10'd8, 32'h5555AAAA);
    send("st_rst", 1'b1, 2'b10, 1'b0, 32'h20, 32'h01234567,
         32'h0, 1'b0, 2, 1'b0, 1'b0, acc);
    chk("st_rst_we_in_wr", {31'h0, bus.mem_we}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("st_rst_we_drop", {31'h0, bus.mem_we}, 32'd0);
    repeat (2) @(negedge clk);
    chk("st_rst_no_resp", {31'h0, bus.resp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("st_rst_ready", {31'h0, bus.req_ready}, 32'd1);
    chk("st_rst_mem", mem[8], 32'h5555AAAA);
    repeat (3) @(negedge clk);

    send("b2b_1", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0,
         32'h5555AAAA, 1'b0, 3, 1'b1, 1'b1, acc);
    chk("b2b_busy_ready", {31'h0, bus.req_ready}, 32'd0);
    send("b2b_2", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
         32'h12340000, 1'b0, 3, 1'b1, 1'b0, acc2);
    chk("b2b_accept_cyc", 32'(acc2), 32'(last_resp + 2));
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: AW, 10, word-address width driven to data memory (depth 2**AW words).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  in  1  core request present.
REQ-006 SHALL have port req_ready  out  1  unit idle and accepting a request.
REQ-007 SHALL have port req_we  in  1  1=store, 0=load.
REQ-008 SHALL have port req_size  in  2  00=byte, 01=half, 10=word; 11 is treated as word.
REQ-009 SHALL have port req_signed  in  1  sign-extend sub-word loads.
REQ-010 SHALL have port req_addr  in  32  byte address.
REQ-011 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-012 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  out  32  load result; 0 for stores.
REQ-014 SHALL have port resp_err  out  1  misaligned request, valid with resp_valid.
REQ-015 SHALL have port mem_a  out  32  word index, {zeros, addr[AW+1:2]}.
REQ-016 SHALL have port mem_wd  out  32  memory write data.
REQ-017 SHALL have port mem_we  out  1  memory write enable.
REQ-018 SHALL have port mem_rd  in  32  memory read data, registered by memory; valid the cycle after address is presented with mem_we=0.

Function
REQ-019 SHALL implement FSM states IDLE, RD, CAP, WR, RESP; req_ready=1 only in IDLE.
REQ-020 SHALL accept on clk edge with req_valid&req_ready, latching we, size, signed, addr, wdata.
REQ-021 SHALL sequence: word store IDLE->WR->RESP; load IDLE->RD->CAP->RESP; byte/half store IDLE->RD->CAP->WR->RESP; RESP->IDLE always.
REQ-022 SHALL yield accept-to-resp_valid latency: word store 2, load 3, sub-word store 4 cycles.
REQ-023 SHALL assert mem_we only in WR, for exactly one cycle per store; mem_we=0 in all other states.
REQ-024 SHALL hold mem_a at the latched word index from RD through WR.
REQ-025 SHALL use little-endian lanes: byte k=addr[1:0] at bits [8k+7:8k]; half at bits [16*addr[1]+15:16*addr[1]].
REQ-026 SHALL, in CAP, extract the lane from mem_rd; zero-extend if req_signed=0, sign-extend if 1; word passes through.
REQ-027 SHALL, for sub-word stores, replace only the addressed lane of captured mem_rd with req_wdata low bits; other lanes unchanged.
REQ-028 SHALL pulse resp_valid for one cycle in RESP with no backpressure; resp_rdata/resp_err hold until next RESP.
REQ-029 SHALL ignore req_valid while not IDLE (request not consumed).
REQ-030 SHALL wrap addresses beyond 2**AW words by truncation to addr[AW+1:2].

Reset
REQ-031 SHALL, on rst low, immediately force state IDLE, mem_we=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_a=0, mem_wd=0, req_ready=1 after release.
REQ-032 SHALL drop an in-flight transaction on reset with no write and no response.

Configuration
REQ-033 SHALL support macro LSU_MISALIGN_CHECK_EN: when defined, half with addr[0]=1 or word with addr[1:0]!=0 goes IDLE->RESP with resp_err=1, resp_rdata=0, no memory access (latency 1).
REQ-034 SHALL, without LSU_MISALIGN_CHECK_EN, ignore addr[0] for half and addr[1:0] for word; resp_err tied 0.

Verification
REQ-035 SHALL test word store addr 0x10 data 0xDEADBEEF then word load 0x10 -> mem_we one cycle with mem_a=4, load resp_rdata=0xDEADBEEF 3 cycles after accept.
REQ-036 SHALL test byte store 0xA5 to addr 0x11 over word 0x11223344 -> memory word 0x1122A544, latency 4, single mem_we pulse.
REQ-037 SHALL test signed byte load addr 0x13 from 0x80000000 -> 0xFFFFFF80; unsigned -> 0x00000080; signed half addr 0x12 -> 0xFFFF8000.
REQ-038 SHALL test misaligned word load addr 0x02 -> with macro resp_err=1 after 1 cycle, no mem access; without macro resp_rdata=word at index 0.
REQ-039 SHALL test rst asserted during WR state of a store -> mem_we drops immediately, no resp_valid, req_ready=1 after release.
REQ-040 SHALL test back-to-back req_valid held high -> second request accepted only the cycle after resp_valid.
